// File: rtl/hough_edge_scanner.sv
// hough_edge_scanner: raster-scans the edge-image BRAM once per start pulse
// and pushes the (x,y) of every pixel at or above EDGE_THRESHOLD into the
// voting FIFO. A one-entry stage (s1) pairs each returned BRAM word with the
// coordinates of the address that produced it. When the FIFO is full on a
// hit, the whole scan freezes and the stalled address is re-presented so the
// data is still valid on the following cycle.
// IMAGE_SIZE is expected to equal WIDTH*HEIGHT.
module hough_edge_scanner #(
    parameter int WIDTH           = 720,
    parameter int HEIGHT          = 540,
    parameter int IMAGE_SIZE      = WIDTH * HEIGHT,
    parameter int BRAM_DATA_WIDTH = 8,
    parameter int EDGE_THRESHOLD  = 1,
    localparam int AW = $clog2(IMAGE_SIZE),
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int CW = $clog2(IMAGE_SIZE + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic [AW-1:0]              bram_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_rd_data,
    input  logic                       out_full,
    output logic                       out_wr_en,
    output logic [XW-1:0]              out_x,
    output logic [YW-1:0]              out_y,
    output logic                       busy,
    output logic                       done,
    output logic [CW-1:0]              edge_count
);

    localparam logic [BRAM_DATA_WIDTH-1:0] THR = BRAM_DATA_WIDTH'(EDGE_THRESHOLD);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           s1_valid_q, s1_valid_d;
    logic [AW-1:0]  s1_addr_q, s1_addr_d;
    logic [XW-1:0]  s1_x_q, s1_x_d;
    logic [YW-1:0]  s1_y_q, s1_y_d;
    logic           done_q, done_d;
    logic [CW-1:0]  edge_count_q, edge_count_d;

    logic hit, stall, last_addr;

    // A hit that cannot be written freezes everything for one cycle.
    assign hit       = s1_valid_q && (bram_rd_data >= THR);
    assign stall     = hit && out_full;
    assign last_addr = (addr_q == AW'(IMAGE_SIZE - 1));

    assign out_wr_en    = hit && !out_full;
    assign out_x        = s1_x_q;
    assign out_y        = s1_y_q;
    // Re-read the stalled pixel so its data is back next cycle.
    assign bram_rd_addr = stall ? s1_addr_q : addr_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign edge_count   = edge_count_q;

    // Next-state: scan counters, s1 stage, completion pulse and edge count.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        x_d          = x_q;
        y_d          = y_q;
        s1_valid_d   = s1_valid_q;
        s1_addr_d    = s1_addr_q;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        done_d       = 1'b0;
        edge_count_d = out_wr_en ? edge_count_q + CW'(1) : edge_count_q;

        case (state_q)
            IDLE: begin
                // A start landing on the done cycle is dropped.
                if (start && !done_q) begin
                    addr_d       = '0;
                    x_d          = '0;
                    y_d          = '0;
                    edge_count_d = '0;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (!stall) begin
                    s1_valid_d = 1'b1;
                    s1_addr_d  = addr_q;
                    s1_x_d     = x_q;
                    s1_y_d     = y_q;
                    addr_d     = last_addr ? '0 : addr_q + AW'(1);
                    if (x_q == XW'(WIDTH - 1)) begin
                        x_d = '0;
                        y_d = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (last_addr) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last pixel is presented here; finish once it is written.
                if (!stall) begin
                    s1_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            done_q       <= 1'b0;
            edge_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            done_q       <= done_d;
            edge_count_q <= edge_count_d;
        end
    end

endmodule

// File: tb/tb_hough_edge_scanner.sv
// Bench for hough_edge_scanner on an 8x4 image. Two instances share the image,
// start and out_full: u0 uses threshold 1, u1 threshold 0x10. A pixel-index
// model predicts every cycle's outputs; literal expectations pin key scans.
module tb_hough_edge_scanner;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       out_full = 1'b0;
    logic [4:0] addr [2];
    logic [7:0] rdat [2];
    logic       wr   [2];
    logic [2:0] ox   [2];
    logic [1:0] oy   [2];
    logic       bsy  [2];
    logic       dno  [2];
    logic [5:0] ec   [2];

    logic [7:0] img [N];
    int thr [2] = '{1, 16};

    int errors = 0;
    int checks = 0;
    int cur_n  = 0;

    // model state: running flag, presented pixel index, writes so far, done due
    int ph [2];
    int p  [2];
    int cnt[2];
    bit dexp[2];

    // write log filled from DUT outputs
    int wcount[2];
    int wx[2][64];
    int wy[2][64];
    int wn[2][64];

    always #5 clock = ~clock;

    hough_edge_scanner #(.WIDTH(W), .HEIGHT(H), .IMAGE_SIZE(N),
                         .BRAM_DATA_WIDTH(8), .EDGE_THRESHOLD(1)) u0 (
        .clock(clock), .reset(reset), .start(start),
        .bram_rd_addr(addr[0]), .bram_rd_data(rdat[0]), .out_full(out_full),
        .out_wr_en(wr[0]), .out_x(ox[0]), .out_y(oy[0]),
        .busy(bsy[0]), .done(dno[0]), .edge_count(ec[0]));

    hough_edge_scanner #(.WIDTH(W), .HEIGHT(H), .IMAGE_SIZE(N),
                         .BRAM_DATA_WIDTH(8), .EDGE_THRESHOLD(16)) u1 (
        .clock(clock), .reset(reset), .start(start),
        .bram_rd_addr(addr[1]), .bram_rd_data(rdat[1]), .out_full(out_full),
        .out_wr_en(wr[1]), .out_x(ox[1]), .out_y(oy[1]),
        .busy(bsy[1]), .done(dno[1]), .edge_count(ec[1]));

    // 1-cycle-latency BRAM read ports
    always @(posedge clock) begin
        rdat[0] <= img[addr[0]];
        rdat[1] <= img[addr[1]];
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (n=%0d)", nm, d, act, exp, cur_n);
        end
    endtask

    // Per-cycle model compare: a scan presents pixels 0..N-1 in order, one per
    // non-stalled cycle, after one empty cycle; done follows the last one.
    always @(negedge clock) begin
        bit run, e, st, w, nd;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                ph[i] = 0; p[i] = -1; cnt[i] = 0; dexp[i] = 0;
                chk("rst_wr", i, wr[i], 0);
                chk("rst_busy", i, bsy[i], 0);
                chk("rst_done", i, dno[i], 0);
                chk("rst_count", i, ec[i], 0);
                chk("rst_addr", i, addr[i], 0);
            end else begin
                run = (ph[i] != 0);
                e = 0; st = 0; w = 0; nd = 0;
                if (run && p[i] >= 0 && p[i] < N) begin
                    e  = (int'(img[p[i]]) >= thr[i]);
                    st = e && out_full;
                    w  = e && !out_full;
                end
                chk("wr_en", i, wr[i], w);
                if (w) begin
                    chk("out_x", i, ox[i], p[i] % W);
                    chk("out_y", i, oy[i], p[i] / W);
                end
                if (wr[i] === 1'b1) begin
                    if (wcount[i] < 64) begin
                        wx[i][wcount[i]] = ox[i];
                        wy[i][wcount[i]] = oy[i];
                        wn[i][wcount[i]] = cur_n;
                    end
                    wcount[i]++;
                end
                chk("busy", i, bsy[i], run);
                chk("done", i, dno[i], dexp[i]);
                chk("edge_count", i, ec[i], cnt[i]);
                if (st) chk("stall_addr", i, addr[i], p[i]);
                else if (run && p[i] + 1 < N) chk("rd_addr", i, addr[i], p[i] + 1);
                if (run) begin
                    if (!st) begin
                        if (w) cnt[i]++;
                        p[i]++;
                        if (p[i] == N) begin ph[i] = 0; nd = 1; end
                    end
                end else if (!dexp[i] && start) begin
                    ph[i] = 1; p[i] = -1; cnt[i] = 0;
                end
                dexp[i] = nd;
            end
        end
    end

    // One scan: fs..fe-1 = out_full cycles (n counts edges after the start
    // edge), sa = literal stall address check, rs_at = start re-pulse cycle,
    // rst_at = reset cycle (aborts), rndf = random out_full, coinc = start on done.
    task automatic run_scan(input int fs, input int fe, input int sa, input int rs_at,
                            input int rst_at, input bit rndf, input bit coinc,
                            output int l0, output int l1);
        int n;
        wcount[0] = 0; wcount[1] = 0;
        l0 = -1; l1 = -1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        n = 0; cur_n = 0;
        while (n < 300) begin
            if (dno[0] && l0 < 0) l0 = n;
            if (dno[1] && l1 < 0) l1 = n;
            if (l0 >= 0 && l1 >= 0) begin
                out_full = 1'b0;
                if (coinc) begin
                    start = 1'b1;
                    @(posedge clock); #1 start = 1'b0;
                    @(posedge clock); #1;
                    chk("start_on_done_ignored", 0, bsy[0], 0);
                    chk("start_on_done_ignored", 1, bsy[1], 0);
                end
                break;
            end
            out_full = rndf ? ($urandom_range(0, 2) == 0) : (n >= fs && n < fe);
            start    = (n == rs_at);
            if (n == rst_at) begin
                reset = 1'b0;
                #1;
                for (int i = 0; i < 2; i++) begin
                    chk("abort_wr", i, wr[i], 0);
                    chk("abort_busy", i, bsy[i], 0);
                    chk("abort_done", i, dno[i], 0);
                    chk("abort_addr", i, addr[i], 0);
                end
                @(posedge clock); #1 reset = 1'b1; start = 1'b0; out_full = 1'b0;
                l0 = -2; l1 = -2;
                return;
            end
            #1;
            if (sa >= 0 && n >= fs && n < fe) begin
                chk("lit_stall_addr", 0, addr[0], sa);
                chk("lit_stall_wr", 0, wr[0], 0);
            end
            @(posedge clock); #1;
            n++; cur_n = n;
        end
        start = 1'b0; out_full = 1'b0;
        chk("scan_finished", 0, l0 >= 0, 1);
        chk("scan_finished", 1, l1 >= 0, 1);
    endtask

    task automatic rand_img();
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
                1: img[k] = 8'($urandom_range(1, 15));
                2: img[k] = 8'($urandom_range(16, 255));
                default: img[k] = 8'h00;
            endcase
        end
    endtask

    initial begin
        int l0, l1, c0;
        for (int k = 0; k < N; k++) img[k] = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // all-zero image, start on done ignored
        run_scan(-1, -1, -1, -1, -1, 1'b0, 1'b1, l0, l1);
        chk("t1_latency", 0, l0, 33);
        chk("t1_writes", 0, wcount[0], 0);
        chk("t1_count", 0, ec[0], 0);

        // single edge pixel at address 19
        img[19] = 8'h80;
        run_scan(-1, -1, -1, -1, -1, 1'b0, 1'b0, l0, l1);
        chk("t2_writes", 0, wcount[0], 1);
        chk("t2_x", 0, wx[0][0], 3);
        chk("t2_y", 0, wy[0][0], 2);
        chk("t2_count", 0, ec[0], 1);
        chk("t2_count", 1, ec[1], 1);

        // threshold boundary: 0x0F at (0,0), 0x10 at (7,3)
        img[19] = 8'h00; img[0] = 8'h0F; img[31] = 8'h10;
        run_scan(-1, -1, -1, -1, -1, 1'b0, 1'b0, l0, l1);
        chk("t3_writes", 1, wcount[1], 1);
        chk("t3_x", 1, wx[1][0], 7);
        chk("t3_y", 1, wy[1][0], 3);
        chk("t3_drain_cycle", 1, wn[1][0], 32);
        chk("t3_count", 1, ec[1], 1);
        chk("t3_writes", 0, wcount[0], 2);

        // all 0xFF, FIFO full 5 cycles while pixel (2,1) sits in s1
        for (int k = 0; k < N; k++) img[k] = 8'hFF;
        run_scan(11, 16, 10, -1, -1, 1'b0, 1'b0, l0, l1);
        chk("t4_latency", 0, l0, 38);
        chk("t4_writes", 0, wcount[0], 32);
        for (int k = 0; k < 32; k++) chk("t4_order", 0, wy[0][k] * W + wx[0][k], k);
        chk("t4_count", 0, ec[0], 32);

        // only the last pixel, FIFO full 3 cycles in the drain cycle
        for (int k = 0; k < N; k++) img[k] = 8'h00;
        img[31] = 8'hFF;
        run_scan(32, 35, 31, -1, -1, 1'b0, 1'b0, l0, l1);
        chk("t5_latency", 0, l0, 36);
        chk("t5_writes", 0, wcount[0], 1);
        chk("t5_x", 0, wx[0][0], 7);
        chk("t5_y", 0, wy[0][0], 3);

        // start re-pulsed mid-scan is ignored
        rand_img();
        c0 = 0;
        for (int k = 0; k < N; k++) if (img[k] != 0) c0++;
        run_scan(-1, -1, -1, 5, -1, 1'b0, 1'b0, l0, l1);
        chk("t6_latency", 0, l0, 33);
        chk("t6_count", 0, ec[0], c0);

        // reset mid-scan aborts; next start rescans from (0,0)
        for (int k = 0; k < N; k++) img[k] = 8'hFF;
        run_scan(-1, -1, -1, -1, 13, 1'b0, 1'b0, l0, l1);
        run_scan(-1, -1, -1, -1, -1, 1'b0, 1'b0, l0, l1);
        chk("t7_first_x", 0, wx[0][0], 0);
        chk("t7_first_y", 0, wy[0][0], 0);
        chk("t7_count", 0, ec[0], 32);

        // random images with random backpressure and stray starts
        for (int r = 0; r < 6; r++) begin
            rand_img();
            run_scan(-1, -1, -1, $urandom_range(1, 40), -1, 1'b1, 1'b0, l0, l1);
        end

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
